// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: shared AES GF(2^8) helpers, widths and the InvMixColumns FSM state type
package aes_gf_pkg;
  localparam int STATE_W = 128;
  localparam int COL_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [7:0] AES_POLY = 8'h1b;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} invMixState_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Encrypt-direction MixColumns on one column, byte 0 in the top bits
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
endpackage

// File: rtl/inv_mix_single_column.sv
// inv_mix_single_column: combinational InvMixColumns of one 32-bit column
module inv_mix_single_column
  import aes_gf_pkg::*;
(
  input  logic [COL_W-1:0] colIn,
  output logic [COL_W-1:0] colOut
);
  logic [BYTE_W-1:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = colIn;
  assign colOut = {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
                   gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
                   gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
                   gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};
endmodule

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: column-serial InvMixColumns with valid/ready handshakes
module inv_mix_columns_seq
  import aes_gf_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadCols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  invMixState_t state;
  logic [1:0] colCnt;
  logic [STATE_W-1:0] workReg, nextWork;
  logic [1:0] colIdx [COLS_PER_CYCLE];
  logic [COL_W-1:0] colIn [COLS_PER_CYCLE];
  logic [COL_W-1:0] colOut [COLS_PER_CYCLE];
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : gCol
    assign colIdx[k] = colCnt + 2'(k);
    assign colIn[k] = workReg[STATE_W-1-COL_W*colIdx[k] -: COL_W];
    inv_mix_single_column uCol (.colIn(colIn[k]), .colOut(colOut[k]));
  end
  always_comb begin
    nextWork = workReg;
    for (int k = 0; k < COLS_PER_CYCLE; k++) nextWork[STATE_W-1-COL_W*colIdx[k] -: COL_W] = colOut[k];
  end
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign state_out = workReg;
  // A capture takes priority so DONE with out_ready and in_valid goes straight back to BUSY
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      colCnt <= '0;
      workReg <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else if (in_valid && in_ready) begin
      state <= BUSY;
      colCnt <= '0;
      workReg <= state_in;
      out_valid <= 1'b0;
      busy <= 1'b1;
    end else if (state == BUSY) begin
      workReg <= nextWork;
      colCnt <= colCnt + STEP;
      if (colCnt == LAST) begin
        state <= DONE;
        out_valid <= 1'b1;
        busy <= 1'b0;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
endmodule
